// File: rtl/md_pkg.sv
// Op codes, FSM state type and op-class decode helpers for the multiply/divide unit.
// The `MD_MACC_EN` macro enables the multiply-accumulate op decode.
package md_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd8;
    localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Long ops occupy the unit for a latency; accumulate ops only exist when enabled.
    function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MACC_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// start is a one-cycle request taken only while busy=0; hi/lo are the architectural registers.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    import md_pkg::*;

    logic                 start;
    logic [MD_OP_W-1:0]   op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_result_calc.sv
// Combinational result datapath: maps op/a/b/HI/LO to the pending {HI,LO}.
// Accumulate adders are present only when `MD_MACC_EN` is defined.
module md_result_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [WIDTH-1:0]   i_hi,
    input  logic [WIDTH-1:0]   i_lo,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [W2-1:0]           w_sprod;
    logic [W2-1:0]           w_uprod;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic [WIDTH-1:0]        w_sdiv_b;
    logic [WIDTH-1:0]        w_udiv_b;
    logic signed [WIDTH-1:0] w_squot;
    logic signed [WIDTH-1:0] w_srem;
    logic [WIDTH-1:0]        w_uquot;
    logic [WIDTH-1:0]        w_urem;

    // Low 2W bits of a sign-extended product equal the signed product.
    assign w_sprod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Special cases are muxed out below; the safe divisor keeps the dividers defined.
    assign w_b_zero = (i_b == '0);
    assign w_ovf    = (i_a == MIN_VAL) && (i_b == '1);
    assign w_sdiv_b = (w_b_zero || w_ovf) ? ONE_VAL : i_b;
    assign w_udiv_b = w_b_zero ? ONE_VAL : i_b;
    assign w_squot  = $signed(i_a) / $signed(w_sdiv_b);
    assign w_srem   = $signed(i_a) % $signed(w_sdiv_b);
    assign w_uquot  = i_a / w_udiv_b;
    assign w_urem   = i_a % w_udiv_b;

`ifdef MD_MACC_EN
    logic [W2-1:0] w_acc;
    assign w_acc = {i_hi, i_lo};
`endif

    always_comb begin
        {o_hi, o_lo} = {i_hi, i_lo};
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_sprod;
            MD_MULTU: {o_hi, o_lo} = w_uprod;
            MD_DIV: begin
                if (w_b_zero)   {o_hi, o_lo} = {i_a, {WIDTH{1'b1}}};
                else if (w_ovf) {o_hi, o_lo} = {{WIDTH{1'b0}}, MIN_VAL};
                else            {o_hi, o_lo} = {w_srem, w_squot};
            end
            MD_DIVU: begin
                if (w_b_zero) {o_hi, o_lo} = {i_a, {WIDTH{1'b1}}};
                else          {o_hi, o_lo} = {w_urem, w_uquot};
            end
`ifdef MD_MACC_EN
            MD_MADD:  {o_hi, o_lo} = w_acc + w_sprod;
            MD_MADDU: {o_hi, o_lo} = w_acc + w_uprod;
            MD_MSUB:  {o_hi, o_lo} = w_acc - w_sprod;
            MD_MSUBU: {o_hi, o_lo} = w_acc - w_uprod;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO; results commit atomically on completion.
// Define `MD_MACC_EN` to add MADD/MADDU/MSUB/MSUBU.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md,
    output md_state_e o_dbg_state
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_long;
    logic             w_div;

    md_result_calc #(.WIDTH(WIDTH)) u_calc (
        .i_op (md.op),
        .i_a  (md.a),
        .i_b  (md.b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo)
    );

    assign w_long = md_is_long(md.op);
    assign w_div  = md_is_div(md.op);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (md.start) begin
                        if (w_long) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_cnt     <= w_div ? DIV_N : MULT_N;
                            r_busy    <= 1'b1;
                            r_state   <= ST_RUN;
                        end else if (md.op == MD_MTHI) begin
                            r_hi <= md.a;
                        end else if (md.op == MD_MTLO) begin
                            r_lo <= md.a;
                        end
                    end
                end
                // start is ignored here; HI/LO hold until the final count.
                ST_RUN: begin
                    if (r_cnt == CNT_1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign md.busy     = r_busy;
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply, divide corner cases, moves, ignored starts, reset abort.
// Accumulate expectations follow `MD_MACC_EN`.
module tb_md_unit;
    import md_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    md_state_e dbg_state;
    int        n_vec  = 0;
    int        n_fail = 0;

    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(32)) md ();

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .md          (md),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by exactly one posedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        @(negedge clk);
        md.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        int   n;
        logic early;
        n     = 0;
        early = 1'b0;
        while (md.busy === 1'b1 && n < 200) begin
            if (md.hi !== old_hi || md.lo !== old_lo) early = 1'b1;
            n++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(n), 32'(exp_cyc));
        check({tag, " hold_during_run"}, 32'(early), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        md.start = 1'b0;
        md.op    = '0;
        md.a     = '0;
        md.b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset hi", md.hi, 32'h0);
        check("reset lo", md.lo, 32'h0);
        check("reset busy", 32'(md.busy), 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));

        issue(MD_MULT, 32'hFFFF_FFFF, 32'h2);
        wait_done("mult", 5, 32'h0, 32'h0);
        check("mult hi", md.hi, 32'hFFFF_FFFF);
        check("mult lo", md.lo, 32'hFFFF_FFFE);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);
        wait_done("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check("multu hi", md.hi, 32'h0000_0001);
        check("multu lo", md.lo, 32'hFFFF_FFFE);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);
        wait_done("div", 10, 32'h0000_0001, 32'hFFFF_FFFE);
        check("div lo", md.lo, 32'hFFFF_FFFD);
        check("div hi", md.hi, 32'hFFFF_FFFF);

        issue(MD_DIVU, 32'h7, 32'h0);
        wait_done("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divu0 lo", md.lo, 32'hFFFF_FFFF);
        check("divu0 hi", md.hi, 32'h0000_0007);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf", 10, 32'h0000_0007, 32'hFFFF_FFFF);
        check("divovf lo", md.lo, 32'h8000_0000);
        check("divovf hi", md.hi, 32'h0);

        issue(MD_MTHI, 32'h1234_5678, 32'h0);
        check("mthi busy", 32'(md.busy), 32'd0);
        check("mthi hi", md.hi, 32'h1234_5678);
        check("mthi lo", md.lo, 32'h8000_0000);
        @(negedge clk);
        check("mthi busy_later", 32'(md.busy), 32'd0);

        issue(MD_MTLO, 32'hA5A5_A5A5, 32'h0);
        check("mtlo lo", md.lo, 32'hA5A5_A5A5);
        check("mtlo hi", md.hi, 32'h1234_5678);

        issue(4'hF, 32'h1, 32'h1);
        check("undef busy", 32'(md.busy), 32'd0);
        check("undef hi", md.hi, 32'h1234_5678);
        check("undef lo", md.lo, 32'hA5A5_A5A5);

        issue(MD_MULT, 32'h5, 32'h6);
        issue(MD_DIV, 32'd100, 32'd7);
        wait_done("ignore", 4, 32'h1234_5678, 32'hA5A5_A5A5);
        check("ignore hi", md.hi, 32'h0);
        check("ignore lo", md.lo, 32'h0000_001E);
        check("ignore state", 32'(dbg_state), 32'(ST_IDLE));

        issue(MD_MULT, 32'h3, 32'h4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(md.busy), 32'd0);
        check("abort lo", md.lo, 32'h0);
        check("abort state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (8) @(negedge clk);
        check("abort no_commit lo", md.lo, 32'h0);
        check("abort no_commit hi", md.hi, 32'h0);
        check("abort busy_later", 32'(md.busy), 32'd0);

        issue(MD_MTHI, 32'h0, 32'h0);
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'h0);
        issue(MD_MADDU, 32'h1, 32'h1);
`ifdef MD_MACC_EN
        wait_done("maddu", 5, 32'h0, 32'hFFFF_FFFF);
        check("maddu hi", md.hi, 32'h0000_0001);
        check("maddu lo", md.lo, 32'h0);
`else
        check("maddu busy", 32'(md.busy), 32'd0);
        repeat (6) @(negedge clk);
        check("maddu hi", md.hi, 32'h0);
        check("maddu lo", md.lo, 32'hFFFF_FFFF);
        check("maddu busy_later", 32'(md.busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
